// File: rtl/imem_loader.sv
// Boot-time program loader and instruction RAM: takes a UART byte stream
// (big-endian word-count header, then that many words), then serves fetch reads.
module imem_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [31:0]       pc,
    output logic [31:0]       odata,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [32:0] DEPTH_33 = 33'd1 << ADDR_W;
    localparam logic [31:0] WC_MAX   = (32'd1 << (ADDR_W + 1)) - 32'd1;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        BODY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [31:0] shift_reg, shift_next;
    logic [31:0] shift_in;
    logic [31:0] n_reg, n_next;
    logic [31:0] cnt_reg, cnt_next;
    logic        err_reg, err_next;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              in_range;

    logic [31:0] mem [DEPTH];

    // Big-endian assembly: each new byte enters the low lane, older bytes move up.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (gi == 0) begin : g_lsb
                assign shift_in[7:0] = rx_data;
            end else begin : g_upper
                assign shift_in[gi*8 +: 8] = shift_reg[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    // Body words beyond the RAM depth are counted but never written.
    assign in_range = (cnt_reg[31:ADDR_W] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= HDR;
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
            n_reg        <= '0;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            shift_reg    <= shift_next;
            n_reg        <= n_next;
            cnt_reg      <= cnt_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        shift_next    = shift_reg;
        n_next        = n_reg;
        cnt_next      = cnt_reg;
        err_next      = err_reg;
        we            = 1'b0;
        waddr         = cnt_reg[ADDR_W-1:0];
        wdata         = shift_in;

        case (state_reg)
            HDR: begin
                if (rx_valid) begin
                    shift_next    = shift_in;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        n_next   = shift_in;
                        cnt_next = '0;
                        if ({1'b0, shift_in} > DEPTH_33) begin
                            err_next = 1'b1;
                        end
                        state_next = (shift_in == 32'd0) ? DONE : BODY;
                    end
                end
            end
            BODY: begin
                if (rx_valid) begin
                    shift_next    = shift_in;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        we       = in_range;
                        cnt_next = cnt_reg + 32'd1;
                        if (cnt_reg + 32'd1 == n_reg) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = HDR;
            end
        endcase
    end

    // Write port: strobes arriving while reset is held are dropped.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port runs in every state; same-address collisions return the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            odata <= '0;
        end else begin
            odata <= mem[pc[ADDR_W+1:2]];
        end
    end

    assign load_done = (state_reg == DONE);
    assign load_err  = err_reg;
    assign word_cnt  = (cnt_reg > WC_MAX) ? '1 : cnt_reg[ADDR_W:0];

    logic unused_bits;
    assign unused_bits = ^{pc[31:ADDR_W+2], pc[1:0], shift_reg[31:24]};

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance (A) and a 4-word
// instance (B) for the oversize-image case; read results go through a scoreboard.
module tb_imem_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default ADDR_W
    logic        a_rst, a_rx_valid, a_done, a_err;
    logic [7:0]  a_rx_data;
    logic [31:0] a_pc, a_odata;
    logic [14:0] a_wc;

    // Instance B: ADDR_W = 2
    logic        b_rst, b_rx_valid, b_done, b_err;
    logic [7:0]  b_rx_data;
    logic [31:0] b_pc, b_odata;
    logic [2:0]  b_wc;

    imem_loader dut_a (
        .clk(clk), .rst(a_rst), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
        .pc(a_pc), .odata(a_odata), .load_done(a_done), .load_err(a_err),
        .word_cnt(a_wc)
    );

    imem_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(b_rst), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .pc(b_pc), .odata(b_odata), .load_done(b_done), .load_err(b_err),
        .word_cnt(b_wc)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        if (sel) begin
            b_rx_data  = b;
            b_rx_valid = 1'b1;
        end else begin
            a_rx_data  = b;
            a_rx_valid = 1'b1;
        end
        @(negedge clk);
        a_rx_valid = 1'b0;
        b_rx_valid = 1'b0;
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w);
        send(sel, w[31:24]);
        send(sel, w[23:16]);
        send(sel, w[15:8]);
        send(sel, w[7:0]);
    endtask

    task automatic do_reset(input bit sel);
        if (sel) b_rst = 1'b1; else a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        b_rst = 1'b0;
    endtask

    // One read per cycle: push the model word, compare when odata lands.
    task automatic rd(input bit sel, input string tag, input logic [31:0] pcv,
                      input logic [31:0] expv);
        logic [31:0] e;
        if (sel) b_pc = pcv; else a_pc = pcv;
        exp_q.push_back(expv);
        @(negedge clk);
        e = exp_q.pop_front();
        chk(tag, sel ? b_odata : a_odata, e);
    endtask

    initial begin
        logic [31:0] pcv;
        int          idx;

        a_rst = 1'b1; b_rst = 1'b1;
        a_rx_valid = 1'b0; b_rx_valid = 1'b0;
        a_rx_data = '0; b_rx_data = '0;
        a_pc = '0; b_pc = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_odata", a_odata, 32'h0);
        chk("rst_done", {31'd0, a_done}, 32'd0);
        chk("rst_err", {31'd0, a_err}, 32'd0);
        chk("rst_wc", 32'(a_wc), 32'd0);
        chk("rst_b_wc", 32'(b_wc), 32'd0);
        a_rst = 1'b0; b_rst = 1'b0;

        // Two-word image
        send_word(0, 32'd2);
        chk("two_hdr_done", {31'd0, a_done}, 32'd0);
        send_word(0, 32'h12345678);
        chk("two_wc1", 32'(a_wc), 32'd1);
        send(0, 8'h9A); send(0, 8'hBC); send(0, 8'hDE);
        chk("two_done_early", {31'd0, a_done}, 32'd0);
        send(0, 8'hF0);
        chk("two_done", {31'd0, a_done}, 32'd1);
        chk("two_wc2", 32'(a_wc), 32'd2);
        chk("two_err", {31'd0, a_err}, 32'd0);
        mdl_a[0] = 32'h12345678;
        mdl_a[1] = 32'h9ABCDEF0;
        rd(0, "two_pc0", 32'd0, mdl_a[0]);
        rd(0, "two_pc4", 32'd4, mdl_a[1]);

        // Random pc stream with junk in ignored bits
        for (int i = 0; i < 40; i++) begin
            idx = int'($urandom_range(0, 1));
            pcv = $urandom();
            pcv[15:2] = 14'(idx);
            rd(0, "rand_pc", pcv, mdl_a[idx]);
        end

        // Empty image
        do_reset(0);
        chk("zero_rst_done", {31'd0, a_done}, 32'd0);
        send_word(0, 32'd0);
        chk("zero_done", {31'd0, a_done}, 32'd1);
        chk("zero_wc", 32'(a_wc), 32'd0);
        send_word(0, 32'h55667788);
        chk("zero_wc_after", 32'(a_wc), 32'd0);
        chk("zero_done_after", {31'd0, a_done}, 32'd1);
        rd(0, "zero_pc0", 32'd0, mdl_a[0]);
        rd(0, "zero_pc4", 32'd4, mdl_a[1]);

        // Back-to-back strobes, pc held at 0 across the write
        do_reset(0);
        a_pc = 32'd0;
        send(0, 8'h00); send(0, 8'h00); send(0, 8'h00); send(0, 8'h01);
        send(0, 8'hAA); send(0, 8'hBB); send(0, 8'hCC);
        chk("b2b_old_pre", a_odata, mdl_a[0]);
        send(0, 8'hDD);
        chk("b2b_old_at_write", a_odata, mdl_a[0]);
        chk("b2b_done", {31'd0, a_done}, 32'd1);
        mdl_a[0] = 32'hAABBCCDD;
        @(negedge clk);
        chk("b2b_new", a_odata, mdl_a[0]);

        // Reset mid-word (with a strobe during reset), then reload
        do_reset(0);
        send_word(0, 32'd2);
        send_word(0, 32'h11223344);
        mdl_a[0] = 32'h11223344;
        chk("mid_wc1", 32'(a_wc), 32'd1);
        send(0, 8'h77); send(0, 8'h66);
        a_rst = 1'b1; a_rx_valid = 1'b1; a_rx_data = 8'hEE;
        @(negedge clk);
        a_rst = 1'b0; a_rx_valid = 1'b0;
        chk("mid_rst_wc", 32'(a_wc), 32'd0);
        chk("mid_rst_done", {31'd0, a_done}, 32'd0);
        send_word(0, 32'd1);
        send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
        chk("mid_done_early", {31'd0, a_done}, 32'd0);
        send(0, 8'h04);
        mdl_a[0] = 32'h01020304;
        chk("mid_done", {31'd0, a_done}, 32'd1);
        chk("mid_wc", 32'(a_wc), 32'd1);
        rd(0, "mid_pc0", 32'd0, mdl_a[0]);
        rd(0, "mid_pc4", 32'd4, mdl_a[1]);

        // Oversize image on the 4-word instance
        send(1, 8'h00); send(1, 8'h00); send(1, 8'h00);
        chk("ovf_err_early", {31'd0, b_err}, 32'd0);
        send(1, 8'h06);
        chk("ovf_err", {31'd0, b_err}, 32'd1);
        chk("ovf_done_hdr", {31'd0, b_done}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] w;
            w = 32'hC0DE0000 + 32'(i) * 32'h01010101;
            if (i < 4) mdl_b[i] = w;
            if (i == 5) chk("ovf_done_early", {31'd0, b_done}, 32'd0);
            send_word(1, w);
        end
        chk("ovf_done", {31'd0, b_done}, 32'd1);
        chk("ovf_wc", 32'(b_wc), 32'd6);
        chk("ovf_err_hold", {31'd0, b_err}, 32'd1);
        for (int i = 0; i < 4; i++) rd(1, "ovf_rd", 32'(i * 4), mdl_b[i]);
        rd(1, "ovf_alias16", 32'd16, mdl_b[0]);
        rd(1, "ovf_alias20", 32'd20, mdl_b[1]);
        rd(1, "ovf_alias_hi", 32'hFFFF_FFEF, mdl_b[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory responder on the fetch side of the core. Receives a program image byte-by-byte from the UART receiver at boot. Assembles big-endian 32-bit words and writes them into an internal synchronous instruction RAM. Once loading completes, it serves the fetch stage's instruction-data bus (`odata`) from the program counter, so the fetch stage can latch `odata` on its valid/finish pulses.

## Interface
- `ADDR_W`, default 14: word-address width; RAM depth is 2^ADDR_W words.
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx_data`  in  8: received UART byte.
- `rx_valid`  in  1: one-cycle strobe; `rx_data` is valid this cycle.
- `pc`  in  32: byte address of the instruction to fetch; bits [1:0] are ignored.
- `odata`  out  32: instruction word read from RAM at `pc[ADDR_W+1:2]`.
- `load_done`  out  1: high once the full image has been received; stays high until reset.
- `load_err`  out  1: header word count exceeded 2^ADDR_W; stays high until reset.
- `word_cnt`  out  ADDR_W+1: number of body words accepted so far.

## Operation
- Image format: a 4-byte header N (big-endian word count), followed by N words. Each word is 4 bytes, most significant byte first.
- FSM states: HDR, BODY, DONE. Reset enters HDR.
- HDR:
  - Each `rx_valid` shifts `rx_data` into the header shift register and increments a 2-bit byte counter.
  - On the 4th byte, N is captured. If N == 0, go to DONE; otherwise go to BODY.
  - `load_err` sets in the same cycle if N > 2^ADDR_W.
- BODY:
  - Each `rx_valid` shifts a byte into the word register.
  - On the 4th byte of a word, write the word to RAM at address `word_cnt[ADDR_W-1:0]` and increment `word_cnt`.
  - Words whose index is ≥ 2^ADDR_W are consumed but not written; the address never wraps.
  - When `word_cnt` reaches N, go to DONE. The transition and the final write happen in the same cycle.
- DONE:
  - `rx_valid` is ignored.
  - `load_done` is 1.
- The read port is independent of the FSM and runs in every state:
  - `odata <= mem[pc[ADDR_W+1:2]]` every cycle.
  - `pc` bits above ADDR_W+1 are ignored, so addresses alias.
- Write and read to the same address in the same cycle: read-first. `odata` shows the old contents.
- RAM contents are not cleared by reset, and are not initialised.

## Timing
- Reset values:
  - `odata` = 0
  - `load_done` = 0
  - `load_err` = 0
  - `word_cnt` = 0
  - FSM = HDR
  - byte counter = 0
- Reset asserted mid-load: the next cycle is HDR with the byte counter at 0. A partially assembled word is discarded. Words already written remain in RAM.
- Read latency is 1 cycle: `pc` presented at edge k gives `odata` valid after edge k+1. The core holds `pc` stable for at least one cycle before asserting its fetch valid.
- The write commits at the edge that samples the 4th byte's `rx_valid`. A read of that address issued at the next edge returns the new word.
- `load_done` rises at the edge sampling the last byte of word N. It rises at the edge sampling the 4th header byte when N == 0.
- `rx_valid` may be high on consecutive cycles; every strobe is accepted, and there is no back-pressure.
- `rx_valid` while `rst` is high is dropped.

## Test plan
- Header 00 00 00 02, then bytes 12 34 56 78 and 9A BC DE F0:
  - `load_done` rises on the 12th byte.
  - `pc`=0 → `odata`=32'h12345678 one cycle later.
  - `pc`=4 → `odata`=32'h9ABCDEF0.
  - `word_cnt`=2.
- Header 00 00 00 00:
  - `load_done`=1 right after the 4th byte.
  - Subsequent `rx_valid` strobes leave `word_cnt`=0 and leave RAM unchanged.
- `ADDR_W`=2, header N=6, 6 words W0..W5:
  - `load_err`=1 after the header.
  - `load_done` rises after W5.
  - `pc`=0..12 reads W0..W3; W4 and W5 are not written.
  - `pc`=16 aliases to W0.
- Back-to-back `rx_valid` on every cycle for 8 bytes (N=1, word AABBCCDD):
  - The word is written correctly.
  - With `pc`=0 held, `odata` changes from old to 32'hAABBCCDD exactly one cycle after the write edge.
- Reset after 2 body bytes of word 1, then reload with N=1, word 01020304:
  - `word_cnt` returns to 0.
  - `pc`=0 → 32'h01020304.
  - `load_done`=1 only after the reload completes.
- Random `pc` stream after load: `odata` at cycle t+1 equals the model's RAM entry at `pc`(t) for every cycle.
